multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle SHA-processor datapath. Sequences every instruction through fetch, decode, execute, memory and writeback.
- Produces the 2-bit alu_op consumed by the ALU control decoder, plus all datapath enables and multiplexer selects.
- Sits between the instruction register (opcode field) and the datapath. Handshakes with memory through mem_ready.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- OP_R, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load-word opcode.
- OP_SW, 6'b101011, store-word opcode.
- OP_BNE, 6'b000101, branch-not-equal opcode.
- OP_J, 6'b000010, jump opcode.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26]; stable from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU not-zero (bne).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback data select: 1 = MDR.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU operand B: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- pc_source  out  2  PC next select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_op  out  2  to ALU control: 00 = jump/add, 01 = memory address, 10 = R-type (funct decides), 11 = bne.
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- retired_count  out  CNT_W  count of retired instructions; wraps.

Behaviour:
- Moore outputs decoded from the state register. Exceptions: ir_write and pc_write in FETCH are gated by mem_ready; illegal_op is gated by opcode. Outputs not listed for a state are 0.
- Reset, asynchronous: state = RST, retired_count = 0. In RST all outputs are 0. RST moves to FETCH on the first clock after reset deasserts.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Hold while mem_ready=0; move to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: R-type → EXEC; LW/SW → MEM_ADDR; BNE → BRANCH; J → JUMP.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, no retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=01. Next state MEM_RD if LW, MEM_WR if SW.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WR:
  - mem_write=1, i_or_d=1.
  - Hold until mem_ready=1; instr_done=mem_ready; then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=11, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, alu_op=00, instr_done=1. Next state FETCH.
- Cycle counts with zero memory wait: R = 4, LW = 5, SW = 4, BNE = 3, J = 3. Each memory wait cycle adds one cycle.
- retired_count increments on every clock where instr_done=1. It wraps from 2^CNT_W−1 to 0 with no flag.
- Reset asserted in any state, including a pending memory wait: immediate return to RST, counter cleared, all outputs 0. A memory access is never completed after reset.
- Opcode changes after DECODE are ignored, except the LW/SW choice made in MEM_ADDR.
- mem_write and reg_write are never 1 in the same cycle. mem_read and mem_write are never both 1.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum typedef (RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP);
  - the opcode constants;
  - the alu_op encoding constants (ALUOP_ADD=00, ALUOP_MEM=01, ALUOP_RTYPE=10, ALUOP_BNE=11), shared with the ALU control decoder;
  - the alu_src_b and pc_source encodings.
- One natural sub-module: retire_counter (CNT_W-bit counter with enable, asynchronous reset).

Test Plan:
- R-type with opcode=000000, mem_ready tied 1 → states FETCH, DECODE, EXEC, R_WB. alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in R_WB; instr_done on cycle 4; retired_count=1.
- LW with opcode=100011 and mem_ready held low 2 cycles in MEM_RD → alu_op=01 in MEM_ADDR; i_or_d=1 and mem_read=1 for 3 cycles; MEM_WB has mem_to_reg=1; total 7 cycles.
- BNE with opcode=000101 → BRANCH asserts alu_op=11, pc_write_cond=1, pc_source=01. J with opcode=000010 → pc_write=1, pc_source=10. Each takes 3 cycles.
- opcode=111111 → illegal_op pulses for exactly the DECODE cycle; returns to FETCH; retired_count unchanged.
- Reset asserted mid-MEM_WR while mem_ready=0 → all outputs 0 immediately, without waiting for a clock; retired_count=0; FETCH on the first clock after release.
- With CNT_W=4, retire 16 back-to-back J instructions → retired_count wraps 15→0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main control FSM and the ALU control decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    RST,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC,
    R_WB,
    BRANCH,
    JUMP
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_MEM   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_BNE   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_main_control_retire_counter.sv
// Wrapping count of retired instructions, cleared by the asynchronous reset.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Advance by one on each retire; natural overflow gives the silent wrap to zero.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM: walks each instruction through fetch, decode, execute,
// memory and writeback, driving every datapath enable and select.
module multicycle_main_control
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_count
);

  state_t state_q;
  state_t state_d;

  // State register; reset drops straight to RST so outputs clear without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; only the FETCH enables, the MEM_WR retire
  // and illegal_op look at inputs.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      RST: begin
        state_d = FETCH;
      end
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_R:         state_d = EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BNE:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_MEM;
        state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = MEM_WB;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_BNE;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: begin
        state_d = RST;
      end
    endcase
  end

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .en    (instr_done),
    .count (retired_count)
  );

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: the stimulus process queues the
// expected outputs of each cycle and an independent monitor pops and compares.
module tb_multicycle_main_control;

  localparam int CNT_W = 4;

  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_BNE = 6'b000101;
  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_BAD = 6'b111111;

  localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_MEM_RD = 4,
                 S_MEM_WB = 5, S_MEM_WR = 6, S_EXEC = 7, S_R_WB = 8, S_BRANCH = 9,
                 S_JUMP = 10;

  typedef struct {
    logic [18:0]      outs;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0]       alu_src_b, pc_source, alu_op;
  logic [CNT_W-1:0] retired_count;

  exp_t             sb_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  multicycle_main_control #(
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op),
    .instr_done    (instr_done),
    .retired_count (retired_count)
  );

  // Expected outputs per state, packed as
  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,
  //  reg_write,alu_src_a,alu_src_b,pc_source,alu_op,illegal_op,instr_done}.
  function automatic logic [18:0] expOutputs(input int st, input logic mr, input logic [5:0] op);
    logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill, done;
    logic [1:0] sb, ps, ao;
    pw = 0; pwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rdst = 0;
    rw = 0; sa = 0; ill = 0; done = 0; sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (st)
      S_FETCH:    begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      S_DECODE:   begin
        sb  = 2'b11;
        ill = !(op == OPC_R || op == OPC_LW || op == OPC_SW || op == OPC_BNE || op == OPC_J);
      end
      S_MEM_ADDR: begin sa = 1; sb = 2'b10; ao = 2'b01; end
      S_MEM_RD:   begin mrd = 1; iord = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; done = 1; end
      S_MEM_WR:   begin mwr = 1; iord = 1; done = mr; end
      S_EXEC:     begin sa = 1; ao = 2'b10; end
      S_R_WB:     begin rw = 1; rdst = 1; done = 1; end
      S_BRANCH:   begin sa = 1; ao = 2'b11; pwc = 1; ps = 2'b01; done = 1; end
      S_JUMP:     begin pw = 1; ps = 2'b10; done = 1; end
      default:    ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ps, ao, ill, done};
  endfunction

  task automatic pushExp(input int st, input logic mr, input logic [5:0] op, input string tag);
    exp_t e;
    e.outs = expOutputs(st, mr, op);
    e.cnt  = exp_cnt;
    e.tag  = tag;
    sb_q.push_back(e);
    if (e.outs[0]) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Drive one cycle's inputs, queue what the DUT must show, then move to the next cycle.
  task automatic applyStimulus(input int st, input logic mr, input logic [5:0] op, input string tag);
    mem_ready = mr;
    opcode    = op;
    pushExp(st, mr, op, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [18:0] act;
    act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op, instr_done};
    checks++;
    if (act !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s outputs actual=%b required=%b", e.tag, act, e.outs);
    end
    checks++;
    if (retired_count !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s retired_count actual=%0d required=%0d", e.tag, retired_count, e.cnt);
    end
  endtask

  // Monitor: compare mid-cycle, and right after any reset rise to catch the async clear.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = OPC_R;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(S_RST, 1, OPC_R, "rst");

    // R-type, no waits
    applyStimulus(S_FETCH,  1, OPC_R, "r.fetch");
    applyStimulus(S_DECODE, 1, OPC_R, "r.decode");
    applyStimulus(S_EXEC,   1, OPC_R, "r.exec");
    applyStimulus(S_R_WB,   1, OPC_R, "r.wb");

    // LW with two wait cycles in MEM_RD
    applyStimulus(S_FETCH,    1, OPC_LW, "lw.fetch");
    applyStimulus(S_DECODE,   1, OPC_LW, "lw.decode");
    applyStimulus(S_MEM_ADDR, 1, OPC_LW, "lw.addr");
    applyStimulus(S_MEM_RD,   0, OPC_LW, "lw.rd.wait1");
    applyStimulus(S_MEM_RD,   0, OPC_LW, "lw.rd.wait2");
    applyStimulus(S_MEM_RD,   1, OPC_LW, "lw.rd.done");
    applyStimulus(S_MEM_WB,   1, OPC_LW, "lw.wb");

    // SW, no waits
    applyStimulus(S_FETCH,    1, OPC_SW, "sw.fetch");
    applyStimulus(S_DECODE,   1, OPC_SW, "sw.decode");
    applyStimulus(S_MEM_ADDR, 1, OPC_SW, "sw.addr");
    applyStimulus(S_MEM_WR,   1, OPC_SW, "sw.wr");

    // BNE and J
    applyStimulus(S_FETCH,  1, OPC_BNE, "bne.fetch");
    applyStimulus(S_DECODE, 1, OPC_BNE, "bne.decode");
    applyStimulus(S_BRANCH, 1, OPC_BNE, "bne.branch");
    applyStimulus(S_FETCH,  1, OPC_J,   "j.fetch");
    applyStimulus(S_DECODE, 1, OPC_J,   "j.decode");
    applyStimulus(S_JUMP,   1, OPC_J,   "j.jump");

    // Fetch wait, then an illegal opcode that must not retire
    applyStimulus(S_FETCH,  0, OPC_BAD, "bad.fetch.wait");
    applyStimulus(S_FETCH,  1, OPC_BAD, "bad.fetch");
    applyStimulus(S_DECODE, 1, OPC_BAD, "bad.decode");

    // R-type whose opcode changes after decode; path must not change
    applyStimulus(S_FETCH,  1, OPC_R, "r2.fetch");
    applyStimulus(S_DECODE, 1, OPC_R, "r2.decode");
    applyStimulus(S_EXEC,   1, OPC_J, "r2.exec.opchg");
    applyStimulus(S_R_WB,   1, OPC_J, "r2.wb");

    // SW interrupted by reset during a memory wait
    applyStimulus(S_FETCH,    1, OPC_SW, "swr.fetch");
    applyStimulus(S_DECODE,   1, OPC_SW, "swr.decode");
    applyStimulus(S_MEM_ADDR, 1, OPC_SW, "swr.addr");
    applyStimulus(S_MEM_WR,   0, OPC_SW, "swr.wr.wait1");
    mem_ready = 1'b0;
    pushExp(S_MEM_WR, 0, OPC_SW, "swr.wr.wait2");
    @(negedge clk);
    #3;
    exp_cnt = '0;
    pushExp(S_RST, 0, OPC_SW, "swr.async_reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(S_RST,   1, OPC_J, "swr.rst.release");
    applyStimulus(S_FETCH, 1, OPC_J, "swr.refetch");

    // Sixteen back-to-back jumps wrap the 4-bit counter
    applyStimulus(S_DECODE, 1, OPC_J, "wrap.decode0");
    applyStimulus(S_JUMP,   1, OPC_J, "wrap.jump0");
    for (int i = 1; i < 16; i++) begin
      applyStimulus(S_FETCH,  1, OPC_J, "wrap.fetch");
      applyStimulus(S_DECODE, 1, OPC_J, "wrap.decode");
      applyStimulus(S_JUMP,   1, OPC_J, "wrap.jump");
    end
    applyStimulus(S_FETCH, 1, OPC_J, "wrap.after");

    @(negedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
